// File: rtl/mem_word_sequencer.sv
// -----------------------------------------------------------------------------
// mem_word_sequencer
//
// Moves one DATA_W-bit word between the datapath and an 8-bit memory as a
// series of byte accesses. The byte order is selectable with BIG_ENDIAN.
// ByteMode transfers only data bits [7:0]. The memory read latency is 0 or
// 1 cycle, set by RD_LAT.
//
// Optional feature: define ALIGN_CHECK_EN to add the Fault output. With it,
// a word request (ByteMode=0) whose address is not a multiple of NB is
// rejected: there is no memory access, and Fault pulses for one cycle.
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous, active-high reset
//   Start        in   request strobe, sampled only while idle
//   WrEn         in   1 = store, 0 = load (sampled with Start)
//   ByteMode     in   1 = single-byte transfer (sampled with Start)
//   Addr         in   base byte address (sampled with Start)
//   WrData       in   store data (sampled with Start)
//   RdData       out  assembled load result, held until the next load ends
//   Busy         out  high from the cycle after acceptance until Done
//   Done         out  one-cycle completion pulse
//   Fault        out  misaligned-request pulse (ALIGN_CHECK_EN only)
//   Mem_Address  out  byte address to memory
//   Mem_Data     out  byte to memory (0 unless storing)
//   Mem_WR       out  write strobe
//   Mem_CS       out  active-low chip select
//   MemOut       in   byte from memory
// -----------------------------------------------------------------------------
module mem_word_sequencer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int RD_LAT     = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              WrEn,
    input  logic              ByteMode,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Busy,
    output logic              Done,
`ifdef ALIGN_CHECK_EN
    output logic              Fault,
`endif
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [7:0]        Mem_Data,
    output logic              Mem_WR,
    output logic              Mem_CS,
    input  logic [7:0]        MemOut
);

    localparam int NB    = DATA_W / 8;
    // The index must be able to hold NB, because it reaches L during DRAIN.
    localparam int IDX_W = $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic                bm_q, bm_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   buf_q, buf_d;     // partial load being assembled
    logic [DATA_W-1:0]   rdata_q, rdata_d; // last completed load
    logic                fault_q, fault_d;

    logic [IDX_W-1:0]    len;
    logic [IDX_W-1:0]    cap_idx;
    logic [IDX_W-1:0]    wr_lane;
    logic [IDX_W-1:0]    cap_lane;
    logic [7:0]          wr_byte;
    logic [DATA_W-1:0]   cap_buf;
    logic                reject;

    // NOTE: sequential state uses non-blocking assignments only, so that every
    // register samples the values from before the edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            bm_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            bm_q    <= bm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        bm_d        = bm_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        idx_d       = idx_q;
        buf_d       = buf_q;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        reject      = 1'b0;
        Busy        = 1'b0;
        Done        = 1'b0;
        Mem_CS      = 1'b1;
        Mem_WR      = 1'b0;
        Mem_Address = '0;
        Mem_Data    = '0;

        len     = bm_q ? IDX_W'(1) : IDX_W'(NB);
        // With RD_LAT=1, the byte arriving now belongs to the previous index.
        cap_idx = idx_q - IDX_W'(RD_LAT);
        // ByteMode always has len=1, so the lane is 0 in both byte orders.
        wr_lane  = BIG_ENDIAN ? (len - IDX_W'(1) - idx_q)   : idx_q;
        cap_lane = BIG_ENDIAN ? (len - IDX_W'(1) - cap_idx) : cap_idx;

        wr_byte = '0;
        cap_buf = buf_q;
        for (int b = 0; b < NB; b++) begin
            if (wr_lane == IDX_W'(b)) begin
                wr_byte = wdata_q[b*8 +: 8];
            end
            if (cap_lane == IDX_W'(b)) begin
                cap_buf[b*8 +: 8] = MemOut;
            end
        end

`ifdef ALIGN_CHECK_EN
        reject = !ByteMode && ((Addr % ADDR_W'(NB)) != '0);
`endif

        case (state_q)
            S_IDLE: begin
                if (Start && reject) begin
                    fault_d = 1'b1;
                end else if (Start) begin
                    wr_d    = WrEn;
                    bm_d    = ByteMode;
                    addr_d  = Addr;
                    wdata_d = WrData;
                    idx_d   = '0;
                    buf_d   = '0;  // ByteMode loads leave the upper bytes zero
                    state_d = S_XFER;
                end
            end

            S_XFER: begin
                Busy        = 1'b1;
                Mem_CS      = 1'b0;
                Mem_WR      = wr_q;
                Mem_Address = addr_q + ADDR_W'(idx_q);  // wraps modulo 2^ADDR_W
                Mem_Data    = wr_q ? wr_byte : 8'h00;
                if (!wr_q && (RD_LAT == 0 || idx_q != '0)) begin
                    buf_d = cap_buf;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == len - IDX_W'(1)) begin
                    if (wr_q || RD_LAT == 0) begin
                        state_d = S_DONE;
                        if (!wr_q) begin
                            rdata_d = cap_buf;
                        end
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                Busy    = 1'b1;
                buf_d   = cap_buf;
                rdata_d = cap_buf;
                state_d = S_DONE;
            end

            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign RdData = rdata_q;
`ifdef ALIGN_CHECK_EN
    assign Fault  = fault_q;
`endif

endmodule

// File: tb/tb_mem_word_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_word_sequencer
//
// Drives two sequencers against one shared byte memory:
//   dut0 : defaults (16-bit word, little-endian, RD_LAT=0)
//   dut1 : 32-bit word, big-endian, RD_LAT=1 (registered read)
// The expected values come from a byte-array model. A store places the bytes
// at Addr+j in the selected byte order. A load assembles the bytes from that
// model. The bench also checks every bus cycle and the cycle of the Done pulse.
// -----------------------------------------------------------------------------
module tb_mem_word_sequencer;

    logic        Clock;
    logic        Reset;
    logic        start0, start1;
    logic        wr_en, byte_mode;
    logic [15:0] addr;
    logic [31:0] wr_data;

    logic [15:0] rd0;
    logic [31:0] rd1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] ma0, ma1;
    logic [7:0]  md0, md1;
    logic        mwr0, mwr1, mcs0, mcs1;
    logic [7:0]  mo0, mo1;
`ifdef ALIGN_CHECK_EN
    logic        fault0, fault1;
`endif

    logic [7:0]  mem     [65536];
    logic [7:0]  ref_mem [65536];
    logic [63:0] prev_rd [2];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    mem_word_sequencer dut0 (
        .Clock(Clock), .Reset(Reset), .Start(start0), .WrEn(wr_en),
        .ByteMode(byte_mode), .Addr(addr), .WrData(wr_data[15:0]),
        .RdData(rd0), .Busy(busy0), .Done(done0),
`ifdef ALIGN_CHECK_EN
        .Fault(fault0),
`endif
        .Mem_Address(ma0), .Mem_Data(md0), .Mem_WR(mwr0), .Mem_CS(mcs0),
        .MemOut(mo0)
    );

    mem_word_sequencer #(
        .DATA_W(32), .ADDR_W(16), .BIG_ENDIAN(1'b1), .RD_LAT(1)
    ) dut1 (
        .Clock(Clock), .Reset(Reset), .Start(start1), .WrEn(wr_en),
        .ByteMode(byte_mode), .Addr(addr), .WrData(wr_data),
        .RdData(rd1), .Busy(busy1), .Done(done1),
`ifdef ALIGN_CHECK_EN
        .Fault(fault1),
`endif
        .Mem_Address(ma1), .Mem_Data(md1), .Mem_WR(mwr1), .Mem_CS(mcs1),
        .MemOut(mo1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Shared byte memory: combinational read for dut0, registered read for dut1.
    assign mo0 = mem[ma0];
    always @(posedge Clock) begin
        mo1 <= mem[ma1];
        if (!mcs0 && mwr0) mem[ma0] = md0;
        if (!mcs1 && mwr1) mem[ma1] = md1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete request on DUT 'sel'. When 'poke' is set, the bench
    // strobes a different request while the DUT is busy; the DUT must ignore it.
    task automatic xfer(input int sel, input bit wr, input bit bm,
                        input logic [15:0] a, input logic [31:0] wd_in, input bit poke);
        int          nb, len, exp_done, n_cs;
        bit          big, rej;
        logic [31:0] wd;
        logic [63:0] exp_rd;
        logic [15:0] ea;
        logic [31:0] tmp;
        logic        busy, done, cs, mwr;
        logic [15:0] ma;
        logic [7:0]  md;
        logic [63:0] rd;

        nb       = (sel == 1) ? 4 : 2;
        big      = (sel == 1);
        len      = bm ? 1 : nb;
        wd       = (sel == 1) ? wd_in : {16'h0, wd_in[15:0]};
        exp_done = len + 1 + ((!wr && sel == 1) ? 1 : 0);
        rej      = 1'b0;
`ifdef ALIGN_CHECK_EN
        rej = !bm && ((int'(a) % nb) != 0);
`endif

        exp_rd = 64'h0;
        for (int j = 0; j < len; j++) begin
            ea = a + 16'(j);
            exp_rd = exp_rd | (64'(ref_mem[ea]) << (8 * (big ? (len - 1 - j) : j)));
        end

        @(negedge Clock);
        wr_en = wr; byte_mode = bm; addr = a; wr_data = wd;
        start0 = (sel == 0); start1 = (sel == 1);

        n_cs = 0;
        for (int c = 1; c <= (rej ? 3 : exp_done); c++) begin
            @(negedge Clock);
            busy = sel ? busy1 : busy0;
            done = sel ? done1 : done0;
            cs   = sel ? mcs1  : mcs0;
            mwr  = sel ? mwr1  : mwr0;
            ma   = sel ? ma1   : ma0;
            md   = sel ? md1   : md0;
            rd   = sel ? 64'(rd1) : 64'(rd0);

            if (rej) begin
                check("rej_cs", 64'(cs), 64'h1);
                check("rej_busy", 64'(busy), 64'h0);
                check("rej_done", 64'(done), 64'h0);
                check("rej_rd", rd, prev_rd[sel]);
`ifdef ALIGN_CHECK_EN
                check("rej_fault", 64'(sel ? fault1 : fault0), 64'(c == 1));
`endif
            end else begin
                if (!cs) begin
                    ea  = a + 16'(n_cs);
                    tmp = wd >> (8 * (big ? (len - 1 - n_cs) : n_cs));
                    check("bus_addr", 64'(ma), 64'(ea));
                    check("bus_wr", 64'(mwr), 64'(wr));
                    check("bus_data", 64'(md), wr ? 64'(tmp[7:0]) : 64'h0);
                    n_cs++;
                end else begin
                    check("idle_wr", 64'(mwr), 64'h0);
                    check("idle_data", 64'(md), 64'h0);
                end
                if (c == exp_done) begin
                    check("done_pulse", 64'(done), 64'h1);
                    check("done_busy", 64'(busy), 64'h0);
                    check("done_cs", 64'(cs), 64'h1);
                    check("byte_cycles", 64'(n_cs), 64'(len));
                    check("rd_data", rd, wr ? prev_rd[sel] : exp_rd);
                end else begin
                    check("early_done", 64'(done), 64'h0);
                    check("busy", 64'(busy), 64'h1);
                    check("rd_held", rd, prev_rd[sel]);
                end
            end

            start0 = 1'b0; start1 = 1'b0;
            wr_en = wr; addr = a;
            if (poke && c == 1) begin
                start0 = (sel == 0); start1 = (sel == 1);
                addr = a ^ 16'h0F0F; wr_en = ~wr;
            end
        end

        @(negedge Clock);
        check("post_done", 64'(sel ? done1 : done0), 64'h0);
        check("post_cs", 64'(sel ? mcs1 : mcs0), 64'h1);

        if (!rej) begin
            if (wr) begin
                for (int j = 0; j < len; j++) begin
                    ea  = a + 16'(j);
                    tmp = wd >> (8 * (big ? (len - 1 - j) : j));
                    ref_mem[ea] = tmp[7:0];
                end
            end else begin
                prev_rd[sel] = exp_rd;
            end
        end
    endtask

    initial begin
        int          sel;
        bit          wr, bm;
        logic [15:0] a;

        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        prev_rd[0] = 64'h0;
        prev_rd[1] = 64'h0;
        Reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        wr_en = 1'b0; byte_mode = 1'b0; addr = '0; wr_data = '0;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_rd0", 64'(rd0), 64'h0);
        check("rst_busy0", 64'(busy0), 64'h0);
        check("rst_done0", 64'(done0), 64'h0);
        check("rst_cs0", 64'(mcs0), 64'h1);
        check("rst_wr0", 64'(mwr0), 64'h0);
        check("rst_addr0", 64'(ma0), 64'h0);
        check("rst_data0", 64'(md0), 64'h0);
        check("rst_cs1", 64'(mcs1), 64'h1);
        check("rst_rd1", 64'(rd1), 64'h0);
`ifdef ALIGN_CHECK_EN
        check("rst_fault0", 64'(fault0), 64'h0);
`endif
        Reset = 1'b0;

        // Directed scenarios
        xfer(0, 1'b1, 1'b0, 16'h0010, 32'h0000ABCD, 1'b0);
        xfer(0, 1'b0, 1'b0, 16'h0010, 32'h0, 1'b0);
        xfer(1, 1'b1, 1'b0, 16'h0100, 32'h11223344, 1'b0);
        xfer(1, 1'b0, 1'b0, 16'h0100, 32'h0, 1'b0);
        xfer(0, 1'b0, 1'b1, 16'h0011, 32'h0, 1'b0);
        xfer(0, 1'b1, 1'b0, 16'hFFFF, 32'h00005A6B, 1'b0);
        xfer(0, 1'b0, 1'b0, 16'hFFFF, 32'h0, 1'b0);
        xfer(1, 1'b0, 1'b0, 16'hFFFE, 32'h0, 1'b1);
        xfer(0, 1'b1, 1'b0, 16'h0020, 32'h00001234, 1'b1);
        xfer(0, 1'b1, 1'b0, 16'h0011, 32'h00007788, 1'b0);
        xfer(1, 1'b1, 1'b1, 16'h0203, 32'hDEADBEEF, 1'b0);
        xfer(1, 1'b0, 1'b1, 16'h0203, 32'h0, 1'b0);

        // Reset in cycle 2 of a 4-byte load aborts it
        @(negedge Clock);
        wr_en = 1'b0; byte_mode = 1'b0; addr = 16'h0200; start1 = 1'b1;
        @(negedge Clock);
        start1 = 1'b0;
        @(negedge Clock);
        #1 Reset = 1'b1;
        #1;
        check("abort_cs", 64'(mcs1), 64'h1);
        check("abort_busy", 64'(busy1), 64'h0);
        check("abort_rd", 64'(rd1), 64'h0);
        @(negedge Clock);
        Reset = 1'b0;
        prev_rd[0] = 64'h0;
        prev_rd[1] = 64'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clock);
            check("abort_no_done", 64'(done1), 64'h0);
            check("abort_idle_cs", 64'(mcs1), 64'h1);
        end

        // Randomized requests against the byte-array model
        for (int t = 0; t < 80; t++) begin
            sel = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            bm  = ($urandom_range(0, 3) == 0);
            a   = ($urandom_range(0, 3) == 0) ? (16'hFFFD + 16'($urandom_range(0, 2)))
                                              : 16'($urandom);
            xfer(sel, wr, bm, a, $urandom, ($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_word_sequencer.md
Name: mem_word_sequencer

Overview:
Parametrised load/store sequencer that moves one DATA_W-bit word between the datapath and the 8-bit memory as a series of byte accesses. It generalises the fixed low/high byte split used for IR loads and memory writes to any multiple-of-8 width, with selectable endianness and a single-byte mode. It sits between the ALU/RF side (request and data) and the Memory block (Address, Data, WR, CS, MemOut).

Parameters:
DATA_W, 16, word width in bits; multiple of 8, 8..64; NB = DATA_W/8 bytes
ADDR_W, 16, memory address width
BIG_ENDIAN, 0, 0: byte at Addr holds bits[7:0]; 1: byte at Addr holds the MS byte
RD_LAT, 0, memory read latency in cycles (0 = MemOut valid in the same cycle as the address, 1 = valid one cycle later)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-high reset
Start  in  1  request strobe; sampled only when Busy=0
WrEn  in  1  1 = store, 0 = load; sampled with Start
ByteMode  in  1  1 = single-byte transfer (data bits[7:0]); sampled with Start
Addr  in  ADDR_W  base address; sampled with Start
WrData  in  DATA_W  store data; sampled with Start
RdData  out  DATA_W  assembled load result; held until the next load completes
Busy  out  1  high from the cycle after Start is accepted until Done
Done  out  1  one-cycle completion pulse
Mem_Address  out  ADDR_W  byte address to memory
Mem_Data  out  8  byte to memory
Mem_WR  out  1  1 = write strobe
Mem_CS  out  1  active-low chip select; 1 when idle
MemOut  in  8  byte from memory

Behaviour:
- Reset values: RdData=0, Busy=0, Done=0, Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0; state IDLE. Reset mid-transfer aborts immediately: no Done pulse, partial RdData discarded.
- States: IDLE, XFER, DRAIN (used only for loads when RD_LAT=1), DONE.
- IDLE: if Start=1, latch WrEn, ByteMode, Addr and WrData; set byte count L = 1 if ByteMode else NB; set index i=0; go to XFER. Start while Busy=1 is ignored and has no side effect.
- XFER: each cycle drives Mem_CS=0, Mem_Address = Addr+i (mod 2^ADDR_W; wrap-around is legal), Mem_WR=WrEn.
  - Byte lane for index i: lane i when BIG_ENDIAN=0; lane L-1-i when BIG_ENDIAN=1. ByteMode always uses lane 0.
  - Stores: Mem_Data = WrData lane.
  - Loads: MemOut is written into the lane for index i-RD_LAT at the clock edge.
  - i increments each cycle. After i=L-1: go to DONE if RD_LAT=0 or store, otherwise go to DRAIN.
- DRAIN: Mem_CS=1; capture the final byte; go to DONE.
- DONE: Done=1, Busy=0 this cycle; RdData updated (upper bytes zero in ByteMode); go to IDLE. A new Start is accepted in the following IDLE cycle.
- Latency from the Start edge to the Done cycle: L+1 cycles for stores and for loads with RD_LAT=0; L+2 cycles for loads with RD_LAT=1.
- Mem_Data=0 and Mem_WR=0 whenever not storing. Mem_CS=0 only during XFER.
- Stores never modify RdData.

Optional Feature:
ALIGN_CHECK_EN. When defined, adds output Fault (1 bit, reset 0). A Start with ByteMode=0 and Addr mod NB != 0 is rejected: no memory access, Busy stays 0, Fault pulses for one cycle, RdData unchanged. When undefined, the Fault port is absent and unaligned and wrapping transfers proceed normally.

Test Plan:
- Defaults: store WrData=0xABCD at Addr=0x0010 -> cycle 1: CS=0, WR=1, addr 0x0010, data 0xCD; cycle 2: addr 0x0011, data 0xAB; Done in cycle 3, Busy low in the Done cycle.
- Load from 0x0010 after the store above (RD_LAT=0) -> RdData=0xABCD on Done; RdData=0 before Done. Repeat with RD_LAT=1 -> same value, Done one cycle later.
- BIG_ENDIAN=1, DATA_W=32: store 0x11223344 at 0x0100 -> bytes 0x11, 0x22, 0x33, 0x44 to addresses 0x0100..0x0103; load back -> 0x11223344.
- ByteMode load at 0x0011 where mem=0xAB -> RdData=0x00AB; only one memory cycle. Store at Addr=0xFFFF, NB=2 -> second byte goes to 0x0000.
- Reset asserted in cycle 2 of a 4-byte load -> Mem_CS=1 and Busy=0 asynchronously; no Done pulse; RdData=0. Start pulses during Busy -> ignored, latched address unchanged.
- ALIGN_CHECK_EN defined: word store at 0x0011 -> Fault pulses, Mem_CS stays 1, no Done pulse.
